// File: rtl/lii_pkg.sv
// -----------------------------------------------------------------------------
// lii_pkg
// Shared definitions for the LII phy adapters:
//   LII_ID_W       - width of the src/dst routing IDs on every flit
//   lii_nbeats()   - number of PW-bit flits needed to carry a DW-bit word
//   lii_sideband_t - per-flit sideband {src, dst, last}
// -----------------------------------------------------------------------------
package lii_pkg;

  localparam int LII_ID_W = 8;

  // Flit count for a word: ceil(dw / pw).
  function automatic int lii_nbeats(input int dw, input int pw);
    return (dw + pw - 1) / pw;
  endfunction

  typedef struct packed {
    logic [LII_ID_W-1:0] src;
    logic [LII_ID_W-1:0] dst;
    logic                last;
  } lii_sideband_t;

endpackage

// File: rtl/lii_tx_serializer.sv
// -----------------------------------------------------------------------------
// lii_tx_serializer
// Transmit-side LII phy adapter. Takes one DW-bit word per handshake from a
// kernel output stream and emits it as NBEATS = ceil(DW/PW) flits of PW bits,
// LSB slice first, with the top slice zero-padded above DW.
//
// Ports:
//   aclk, arst      - clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready
//                   - kernel word stream (input side)
//   lii_out_tdata/lii_out_tvalid/lii_out_tready
//                   - flit stream (output side)
//   lii_out_src/dst - constant routing IDs (SRC_ID/DST_ID), driven in reset too
//   lii_out_tlast   - high on the final flit of a word
//   busy            - FSM state visibility: high while in SEND
//
// Handshake semantics (both streams): a transfer happens on a rising edge
// where valid and ready are both high. Once valid is high, the source holds
// its data (and tlast) unchanged until that transfer; valid never depends on
// ready. The only combinational input-to-output path is s_tready, which
// depends on lii_out_tready so a new word can be accepted in the same cycle
// the last flit of the current word leaves (zero-bubble back-to-back).
// -----------------------------------------------------------------------------
module lii_tx_serializer
  import lii_pkg::*;
#(
  parameter int                  DW     = 384,
  parameter int                  PW     = 64,
  parameter logic [LII_ID_W-1:0] SRC_ID = 8'h00,
  parameter logic [LII_ID_W-1:0] DST_ID = 8'h00
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic [DW-1:0]       s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [PW-1:0]       lii_out_tdata,
  output logic                lii_out_tvalid,
  input  logic                lii_out_tready,
  output logic [LII_ID_W-1:0] lii_out_src,
  output logic [LII_ID_W-1:0] lii_out_dst,
  output logic                lii_out_tlast,
  output logic                busy
);

  localparam int NBEATS = lii_nbeats(DW, PW);
  localparam int HW     = NBEATS * PW;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_beat;
  logic [HW-1:0] r_hold;   // shifts right one slice per flit; low PW bits are on the wire

  logic          w_send;
  logic          w_last;
  logic          w_flit_hs;
  logic          w_accept;
  lii_sideband_t w_sb;

  assign w_send    = (r_state == ST_SEND);
  assign w_last    = w_send && (r_beat == LAST_BEAT);
  assign w_flit_hs = w_send && lii_out_tready;

  // Gated by arst so the kernel never sees ready while the block is held in reset.
  assign s_tready  = !arst && (!w_send || (w_last && lii_out_tready));
  assign w_accept  = s_tvalid && s_tready;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_hold  <= '0;
    end else if (w_accept) begin
      // Covers both the IDLE start and the last-flit/new-word overlap.
      r_state <= ST_SEND;
      r_beat  <= '0;
      r_hold  <= HW'(s_tdata);
    end else if (w_flit_hs) begin
      if (w_last) begin
        r_state <= ST_IDLE;
        r_beat  <= '0;
        r_hold  <= '0;
      end else begin
        r_beat  <= r_beat + 1'b1;
        r_hold  <= r_hold >> PW;
      end
    end
  end

  assign w_sb = '{src: SRC_ID, dst: DST_ID, last: w_last};

  assign lii_out_tdata  = r_hold[PW-1:0];
  assign lii_out_tvalid = w_send;
  assign busy           = w_send;
  assign lii_out_tlast  = w_sb.last;
  assign lii_out_src    = w_sb.src;
  assign lii_out_dst    = w_sb.dst;

endmodule
